seg_scan_ctrl: RTL

- Display controller for the 4-digit 7-segment output of the RNG board.
- Accepts a binary value (e.g. the randomised number) on a load strobe.
- Converts it to BCD with a sequential shift-add-3 (double-dabble) engine, one iteration per cycle.
- Time-multiplexes the four digits onto shared active-low anode/cathode lines, one digit per CLK500Hz cycle.

---
 rtl/seg_pkg.sv | 33 +++
 rtl/seg7_decode.sv | 33 +++
 rtl/seg_scan_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// ============================================================================
// seg_pkg : shared types and constants for the 7-segment scan controller
// Revision: 1.0
// ============================================================================
`default_nettype none

package seg_pkg;

  localparam int BCD_W       = 4;
  localparam int MAX_DISPLAY = 9999;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

  // Active-low cathodes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// ============================================================================
// seg7_decode : 4-bit BCD to active-low 7-segment, non-BCD codes blank
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
// ============================================================================
// seg_scan_ctrl : double-dabble BCD conversion plus 4-digit multiplexed scan
//                 Optional macro LEAD_ZERO_BLANK_EN blanks leading zeros.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int VALUE_W    = 14
) (
  input  logic                  CLK500Hz,
  input  logic                  rstn,
  input  logic                  load,
  input  logic [VALUE_W-1:0]    value,
  output logic                  busy,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int BCD_TOT = NUM_DIGITS * BCD_W;
  localparam int ADJ_W   = (NUM_DIGITS - 1) * BCD_W;
  localparam int ITER_W  = $clog2(VALUE_W);
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  state_t                            state_q, state_d;
  logic [VALUE_W-1:0]                bin_q, bin_d;
  logic [BCD_TOT-1:0]                bcd_q, bcd_d;
  logic [ITER_W-1:0]                 iter_q, iter_d;
  logic [NUM_DIGITS-1:0][BCD_W-1:0]  digits_q, digits_d;
  logic [IDX_W-1:0]                  scan_idx_q, scan_idx_d;
  logic [NUM_DIGITS-1:0]             an_q, an_d;
  logic [6:0]                        seg_q, seg_d;

  logic [VALUE_W-1:0] value_clamped;
  logic [ADJ_W-1:0]   bcd_adj;
  logic [6:0]         dec_seg;
  logic               blank_sel;

  assign value_clamped = (value > VALUE_W'(MAX_DISPLAY)) ? VALUE_W'(MAX_DISPLAY) : value;

  // The top digit never reaches 5 before its final shift (input <= 9999),
  // so only the lower nibbles need the add-3 correction.
  always_comb begin
    bcd_adj = bcd_q[ADJ_W-1:0];
    for (int i = 0; i < NUM_DIGITS - 1; i++) begin
      if (bcd_q[i*BCD_W +: BCD_W] >= 4'd5) begin
        bcd_adj[i*BCD_W +: BCD_W] = bcd_q[i*BCD_W +: BCD_W] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    iter_d   = iter_q;
    digits_d = digits_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          bin_d   = value_clamped;
          bcd_d   = '0;
          iter_d  = '0;
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        bin_d  = bin_q << 1;
        bcd_d  = {bcd_q[BCD_TOT-2 -: BCD_W-1], bcd_adj, bin_q[VALUE_W-1]};
        iter_d = iter_q + 1'b1;
        if (iter_q == ITER_W'(VALUE_W - 1)) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        digits_d = bcd_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef LEAD_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic                  zero_run;

  // Walk down from the top digit; digit 0 always stays visible.
  always_comb begin
    blank_d  = blank_q;
    zero_run = 1'b1;
    if (state_q == ST_COMMIT) begin
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
        zero_run   = zero_run & (bcd_q[i*BCD_W +: BCD_W] == '0);
        blank_d[i] = zero_run;
      end
      blank_d[0] = 1'b0;
    end
  end

  always_ff @(posedge CLK500Hz) begin
    if (!rstn) begin
      blank_q <= '0;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign blank_sel = blank_q[scan_idx_q];
`else
  assign blank_sel = 1'b0;
`endif

  seg7_decode u_decode (
    .bcd (digits_q[scan_idx_q]),
    .seg (dec_seg)
  );

  always_comb begin
    scan_idx_d = scan_idx_q + 1'b1;
    an_d       = ~(NUM_DIGITS'(1) << scan_idx_q);
    seg_d      = blank_sel ? SEG_BLANK : dec_seg;
  end

  always_ff @(posedge CLK500Hz) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      digits_q   <= '0;
      scan_idx_q <= '0;
      an_q       <= '1;
      seg_q      <= SEG_BLANK;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      iter_q     <= iter_d;
      digits_q   <= digits_d;
      scan_idx_q <= scan_idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = 1'b1;

endmodule

`default_nettype wire
